// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction-fetch front end feeding the decode stage.
// Issues reads to a 1-cycle-latency instruction memory, buffers the returned
// words with their PC in a small FIFO, and hands them to decode with a
// valid/ready handshake. A redirect flushes buffered and in-flight words and
// restarts fetch at the redirect target.
// Optional feature macro: FETCH_STATS_EN adds a saturating discard_count port
// that accumulates the number of words thrown away by redirects.
module if_prefetch_queue #(
    parameter int               ISIZE    = 16,
    parameter int               DSIZE    = 16,
    parameter int               DEPTH    = 4,
    parameter logic [ISIZE-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_en,
    output logic [ISIZE-1:0] imem_addr,
    input  logic [DSIZE-1:0] imem_data,
    input  logic             redirect_valid,
    input  logic [ISIZE-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_inst,
    output logic [ISIZE-1:0] out_pc,
    output logic [ISIZE-1:0] out_next_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]      discard_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Fetch-side control state
    logic [ISIZE-1:0] fetch_pc;
    logic             req_pending;
    logic [ISIZE-1:0] pending_pc;

    // Buffer state
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [ISIZE-1:0] fifo_pc   [DEPTH];
    logic [DSIZE-1:0] fifo_inst [DEPTH];

    // Registered copy of the head entry driving decode
    logic [ISIZE-1:0] head_pc;
    logic [DSIZE-1:0] head_inst;

    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] count_after_pop;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic             issue;
    logic             push;
    logic             pop;

`ifdef FETCH_STATS_EN
    // Saturating 16-bit accumulate used by the discard statistics counter
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction
`endif

    // Issue/push/pop decisions; redirect and reset override everything
    always_comb begin
        occupancy       = count + CNT_W'(req_pending);
        issue           = !rst && !redirect_valid && (occupancy < CNT_W'(DEPTH));
        push            = !rst && !redirect_valid && req_pending;
        out_valid       = !rst && !redirect_valid && (count != '0);
        pop             = out_valid && out_ready;
        count_after_pop = count - CNT_W'(pop);
        rd_ptr_nxt      = rd_ptr + PTR_W'(1);
    end

    // Memory request and decode-facing outputs (head comes from a register only)
    always_comb begin
        imem_en     = issue;
        imem_addr   = rst ? RESET_PC : fetch_pc;
        out_pc      = rst ? '0 : head_pc;
        out_inst    = rst ? '0 : head_inst;
        out_next_pc = rst ? ISIZE'(1) : head_pc + ISIZE'(1);
    end

    // Control state: fetch PC, in-flight flag, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            req_pending <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_pc;
            req_pending <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            req_pending <= issue;
            if (issue)
                fetch_pc <= fetch_pc + ISIZE'(1);
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr_nxt;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Remember the address of the read in flight so the returning word gets its PC
    always_ff @(posedge clk) begin
        if (issue)
            pending_pc <= fetch_pc;
    end

    // FIFO storage write of the returning word at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= pending_pc;
            fifo_inst[wr_ptr] <= imem_data;
        end
    end

    // Head register: follows the head entry, holds when the buffer drains
    always_ff @(posedge clk) begin
        if (rst) begin
            head_pc   <= '0;
            head_inst <= '0;
        end else if (!redirect_valid) begin
            if (push && (count_after_pop == '0)) begin
                head_pc   <= pending_pc;
                head_inst <= imem_data;
            end else if (pop && (count_after_pop != '0)) begin
                head_pc   <= fifo_pc[rd_ptr_nxt];
                head_inst <= fifo_inst[rd_ptr_nxt];
            end
        end
    end

`ifdef FETCH_STATS_EN
    // Count words (buffered plus in flight) thrown away by each redirect cycle
    always_ff @(posedge clk) begin
        if (rst)
            discard_count <= '0;
        else if (redirect_valid)
            discard_count <= sat_add16(discard_count, 16'(occupancy));
    end
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_if_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic [15:0] out_next_pc;
`ifdef FETCH_STATS_EN
    logic [15:0] discard_count;
`endif

    always #5 clk = ~clk;

    if_prefetch_queue #(
        .ISIZE(16), .DSIZE(16), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_en(imem_en),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst(out_inst),
        .out_pc(out_pc),
        .out_next_pc(out_next_pc)
`ifdef FETCH_STATS_EN
        ,
        .discard_count(discard_count)
`endif
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    // Instruction memory with one cycle of read latency
    always @(posedge clk) imem_data <= mem_word(imem_addr);

    // Reference model state
    logic [15:0] m_fetch_pc;
    logic [15:0] m_pend_pc;
    bit          m_pend;
    logic [31:0] m_q[$];
    logic [15:0] m_last_pc;
    logic [15:0] m_last_inst;
    int          m_disc;
    int          n_vec = 0;
    int          n_err = 0;
    bit          saw_0010;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, compare against the model, advance the model
    task automatic step(input bit r, input bit rv, input logic [15:0] rpc, input bit rdy);
        bit          e_en, e_val;
        logic [15:0] e_pc, e_inst;
        rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        #1;
        n_vec++;
        e_en  = !r && !rv && ((m_q.size() + int'(m_pend)) < DEPTH);
        e_val = !r && !rv && (m_q.size() != 0);
        chk("imem_en", imem_en, e_en);
        if (e_en || r) chk("imem_addr", imem_addr, r ? RESET_PC : m_fetch_pc);
        chk("out_valid", out_valid, e_val);
        if (r) begin
            e_pc = 16'h0000; e_inst = 16'h0000;
        end else if (e_val) begin
            e_pc = m_q[0][31:16]; e_inst = m_q[0][15:0];
        end else begin
            e_pc = m_last_pc; e_inst = m_last_inst;
        end
        chk("out_pc", out_pc, e_pc);
        chk("out_inst", out_inst, e_inst);
        chk("out_next_pc", out_next_pc, 16'(e_pc + 16'd1));
`ifdef FETCH_STATS_EN
        if (!r) chk("discard_count", discard_count, m_disc);
`endif
        if (imem_en === 1'b1 && imem_addr === 16'h0010) saw_0010 = 1'b1;
        @(posedge clk);
        if (r) begin
            m_fetch_pc = RESET_PC; m_pend = 0; m_q.delete();
            m_last_pc = 16'h0000; m_last_inst = 16'h0000; m_disc = 0;
        end else if (rv) begin
            m_disc = m_disc + m_q.size() + int'(m_pend);
            if (m_disc > 65535) m_disc = 65535;
            m_q.delete(); m_pend = 0; m_fetch_pc = rpc;
        end else begin
            if (e_val && rdy) void'(m_q.pop_front());
            if (m_pend) m_q.push_back({m_pend_pc, mem_word(m_pend_pc)});
            m_pend = e_en;
            if (e_en) begin
                m_pend_pc  = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 16'd1;
            end
            if (m_q.size() != 0) {m_last_pc, m_last_inst} = m_q[0];
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] seq [4];
        seq = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        saw_0010 = 1'b0;
        @(negedge clk);

        // Streaming from reset release
        step(1, 0, 0, 1); step(1, 0, 0, 1);
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        #1;
        chk("first_valid", out_valid, 1'b1);
        chk("first_pc", out_pc, 16'h0000);
        chk("first_inst", out_inst, 16'h1000);
        chk("first_next_pc", out_next_pc, 16'h0001);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
        #1 chk("stream_pc", out_pc, 16'h0006);

        // Decode stalled: fill to DEPTH then drain in order
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        #1 chk("full_no_issue", imem_en, 1'b0);
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            #1 chk("drain_pc", out_pc, i);
            step(0, 0, 0, 1);
        end

        // Redirect with 3 buffered and 1 in flight
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 1, 16'h0040, 0);
        redirect_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("redir_en", imem_en, 1'b1);
        chk("redir_addr", imem_addr, 16'h0040);
`ifdef FETCH_STATS_EN
        chk("redir_discard", discard_count, 16'd4);
`endif
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        #1;
        chk("redir_valid", out_valid, 1'b1);
        chk("redir_pc", out_pc, 16'h0040);

        // Redirect near the top of the address space
        step(0, 1, 16'hFFFE, 1);
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            #1 chk("wrap_pc", out_pc, seq[i]);
            if (i == 1) chk("wrap_next_pc", out_next_pc, 16'h0000);
            step(0, 0, 0, 1);
        end

        // Back-to-back redirects: the last one wins
        saw_0010 = 1'b0;
        step(0, 1, 16'h0010, 1); step(0, 1, 16'h0020, 1);
        redirect_valid = 1'b0;
        #1 chk("b2b_addr", imem_addr, 16'h0020);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        chk("b2b_no_0010", saw_0010, 1'b0);

        // One-cycle reset mid-stream with 2 entries buffered
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        rst = 1'b0;
        #1 chk("rst_mid_valid", out_valid, 1'b0);
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        #1;
        chk("rst_mid_restart_valid", out_valid, 1'b1);
        chk("rst_mid_restart_pc", out_pc, RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit          r, rv, rdy;
            logic [15:0] rpc;
            r   = ($urandom % 200) == 0;
            rv  = ($urandom % 16) == 0;
            rdy = ($urandom % 4) != 0;
            rpc = (($urandom % 4) == 0) ? 16'(16'hFFFC + ($urandom % 4)) : 16'($urandom);
            step(r, rv, rpc, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of the decode/ID stage. It drives the instruction memory, which has 1-cycle read latency. Returned words are buffered in a small FIFO tagged with their PC, so fetch continues while decode stalls. Each entry is presented to decode with a valid/ready handshake. A redirect input (branch/jump/jr target resolved downstream) flushes all buffered and in-flight words and restarts fetch at the target.

Parameters:
ISIZE, 16, PC / instruction-address width
DSIZE, 16, instruction word width
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
imem_en  out  1  read request to instruction memory this cycle
imem_addr  out  ISIZE  read address; data returns on imem_data next cycle
imem_data  in  DSIZE  read data for the request issued the previous cycle
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  ISIZE  new fetch address
out_valid  out  1  head entry valid for decode
out_ready  in  1  decode accepts head entry
out_inst  out  DSIZE  head instruction word
out_pc  out  ISIZE  head entry PC
out_next_pc  out  ISIZE  out_pc + 1, modulo 2^ISIZE

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- State: fetch_pc, req_pending (read issued last cycle), pending_pc, FIFO of DEPTH {pc, inst} entries, count (0..DEPTH).
- Reset values: fetch_pc=RESET_PC, req_pending=0, count=0.
- Outputs while rst is high: imem_en=0, imem_addr=RESET_PC, out_valid=0, out_inst=0, out_pc=0, out_next_pc=1.
- Issue rule: imem_en=1 iff !rst && !redirect_valid && (count + req_pending) < DEPTH.
  - imem_addr=fetch_pc whenever imem_en=1.
  - On issue: fetch_pc<=fetch_pc+1 (wraps FFFF->0000), req_pending<=1, pending_pc<=fetch_pc.
  - No issue: req_pending<=0.
- Push: if req_pending && !redirect_valid, write {pending_pc, imem_data} at the tail. The issue rule guarantees space, so a push never overflows.
- Pop: out_valid = (count!=0) && !redirect_valid. The head advances when out_valid && out_ready.
- Simultaneous push and pop: count unchanged; both the head and tail pointers advance.
- Outputs: out_inst, out_pc and out_next_pc come from the head entry register, with no combinational path from imem_data.
  - When count==0, they hold their last values; decode must ignore them while out_valid=0.
- Redirect (has priority over push, pop and issue):
  - count<=0 and req_pending<=0; the word returning this cycle is dropped.
  - fetch_pc<=redirect_pc; imem_en=0 this cycle; out_valid=0.
  - The next cycle issues redirect_pc. Back-to-back redirects: the last one wins.
- Latency:
  - Reset release or redirect at cycle N: first issue at N+1, data pushed at the end of N+2, out_valid=1 at N+3.
  - From reset release specifically: issue at cycle 0, out_valid at cycle 2 with out_pc=RESET_PC.
- Throughput: one instruction per cycle sustained when out_ready stays high.
- Full condition: when count + req_pending == DEPTH, issue stops until a pop occurs. A pop in the same cycle does not enable issue; this is the conservative credit scheme.
- Reset mid-operation: all state returns to reset values next edge; any in-flight data is ignored.
- Pointer arithmetic is modulo DEPTH; PC arithmetic is modulo 2^ISIZE.

Optional Feature:
Macro FETCH_STATS_EN.
- Defined: adds output port discard_count (16 bits), reset to 0. Each redirect_valid cycle adds (count + req_pending) to it, saturating at 16'hFFFF.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset released, RESET_PC=0, out_ready=1, memory holds mem[i]=i+16'h1000 -> out_valid rises at cycle 2 with out_pc=0, out_inst=16'h1000, out_next_pc=1; then one entry per cycle, pc 1,2,3...
- out_ready=0 after reset -> exactly DEPTH=4 issues (addr 0..3), then imem_en=0, count=4. Raise out_ready -> entries pc 0,1,2,3 in order, no loss or duplicates.
- Streaming; redirect_valid=1 with redirect_pc=16'h0040 while 3 entries are buffered and 1 is in flight -> out_valid=0 that cycle, next issue addr 16'h0040, next out_pc=16'h0040. No pre-redirect word ever appears. With FETCH_STATS_EN, discard_count=4.
- Redirect to 16'hFFFE, stream -> out_pc sequence FFFE, FFFF, 0000, 0001; out_next_pc at FFFF = 0000.
- Redirect on two consecutive cycles (targets 16'h0010 then 16'h0020) -> only 16'h0020 is fetched; 16'h0010 never appears on imem_addr.
- rst asserted for one cycle mid-stream with 2 entries buffered -> out_valid=0 the next cycle. The fetch restarts at RESET_PC, and the first out_pc after restart is RESET_PC.
